// File: rtl/motor_spi_pwm.sv
// SPI-commanded multi-channel signed PWM motor driver with H-bridge direction outputs.
// Optional watchdog enabled by defining WATCHDOG_EN.
module motor_spi_pwm #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned DUTY_W      = 8,
   parameter int unsigned PRESCALE    = 1,
   parameter int unsigned WDOG_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              sdi,
   input  logic              load,
   output logic              sdo,
   output logic [NUM_CH-1:0] en,
   output logic [NUM_CH-1:0] dir_a,
   output logic [NUM_CH-1:0] dir_b,
   output logic              frame_err,
   output logic              wdog_trip
);

   localparam int unsigned FrameW = NUM_CH * DUTY_W;
   localparam int unsigned CntW   = $clog2(FrameW + 2);
   localparam int unsigned MagW   = DUTY_W - 1;
   localparam int unsigned PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [MagW-1:0] MagFull = {MagW{1'b1}};
   // Last PWM count is P-1 = 2^MagW - 2
   localparam logic [MagW-1:0] PwmLast = {{(MagW-1){1'b1}}, 1'b0};
   localparam logic [DUTY_W-1:0] CmdMin = {1'b1, {(DUTY_W-1){1'b0}}};

   logic [2:0]        sck_q, load_q;
   logic [1:0]        sdi_q;
   logic [FrameW-1:0] shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [FrameW-1:0] shadow_q, shadow_d;
   logic [FrameW-1:0] active_q, active_d;
   logic [PreW-1:0]   pre_q, pre_d;
   logic [MagW-1:0]   pwm_q, pwm_d;
   logic [NUM_CH-1:0] en_q, en_d, dira_q, dira_d, dirb_q, dirb_d;
   logic              ferr_q, ferr_d;
   logic              sck_rise, load_rise, load_fall, shift_en, commit, tick, wrap;

   logic [DUTY_W-1:0] cmd [NUM_CH];
   logic [MagW-1:0]   mag [NUM_CH];

   assign sck_rise  = sck_q[1] & ~sck_q[2];
   assign load_rise = load_q[1] & ~load_q[2];
   assign load_fall = ~load_q[1] & load_q[2];
   // load_q[2] keeps a bit that coincides with the load falling edge
   assign shift_en  = sck_rise & (load_q[1] | load_q[2]);

`ifdef WATCHDOG_EN
   localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic             trip_q, trip_d;
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
`endif

   always_comb begin
      shift_d = shift_q;
      cnt_d   = load_rise ? '0 : cnt_q;
      if (shift_en) begin
         shift_d = {shift_q[FrameW-2:0], sdi_q[1]};
         if (cnt_d != CntW'(FrameW + 1)) cnt_d = cnt_d + 1'b1;
      end
      commit = load_fall && (cnt_d == CntW'(FrameW));
      ferr_d = load_fall && !commit;

      tick  = (pre_q == PreW'(PRESCALE - 1));
      pre_d = tick ? '0 : pre_q + 1'b1;
      wrap  = tick && (pwm_q == PwmLast);
      pwm_d = pwm_q;
      if (tick) pwm_d = wrap ? '0 : pwm_q + 1'b1;

      shadow_d = commit ? shift_d : shadow_q;
      active_d = wrap ? shadow_q : active_q;

`ifdef WATCHDOG_EN
      wdog_d = wdog_q;
      trip_d = trip_q;
      if (commit) begin
         wdog_d = '0;
         trip_d = 1'b0;
      end else if (wdog_q != WdogW'(WDOG_CYCLES)) begin
         wdog_d = wdog_q + 1'b1;
         if (wdog_d == WdogW'(WDOG_CYCLES)) begin
            trip_d   = 1'b1;
            shadow_d = '0;
            active_d = '0;
         end
      end
`endif
   end

   // Outputs are registered from next-state values so they track the counter without lag
   always_comb begin
      en_d   = '0;
      dira_d = '0;
      dirb_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cmd[i] = active_d[(NUM_CH-1-i)*DUTY_W +: DUTY_W];
         if (cmd[i] == CmdMin) mag[i] = MagFull;
         else if (cmd[i][DUTY_W-1]) mag[i] = MagW'(~cmd[i] + 1'b1);
         else mag[i] = cmd[i][MagW-1:0];
         en_d[i]   = (pwm_d < mag[i]);
         dira_d[i] = !cmd[i][DUTY_W-1] && (cmd[i] != '0);
         dirb_d[i] = cmd[i][DUTY_W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q    <= '0;
         sdi_q    <= '0;
         load_q   <= '0;
         shift_q  <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= '0;
         pre_q    <= '0;
         pwm_q    <= '0;
         en_q     <= '0;
         dira_q   <= '0;
         dirb_q   <= '0;
         ferr_q   <= 1'b0;
      end else begin
         sck_q    <= {sck_q[1:0], sck};
         sdi_q    <= {sdi_q[0], sdi};
         load_q   <= {load_q[1:0], load};
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         pre_q    <= pre_d;
         pwm_q    <= pwm_d;
         en_q     <= en_d;
         dira_q   <= dira_d;
         dirb_q   <= dirb_d;
         ferr_q   <= ferr_d;
      end
   end

`ifdef WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
         trip_q <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         trip_q <= trip_d;
      end
   end
   assign wdog_trip = trip_q;
`else
   assign wdog_trip = 1'b0;
`endif

   assign sdo       = shift_q[FrameW-1];
   assign en        = en_q;
   assign dir_a     = dira_q;
   assign dir_b     = dirb_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_motor_spi_pwm.sv
// Directed self-checking bench for motor_spi_pwm: default 2x8 instance plus a 3x12 instance.
// Watchdog scenario is exercised when WATCHDOG_EN is defined.
module tb_motor_spi_pwm;

   logic       clk = 1'b0;
   logic       reset;
   logic       sck, sdi, load, sdo, frame_err, wdog_trip;
   logic [1:0] en, dir_a, dir_b;
   logic       sck3, sdi3, load3, sdo3, ferr3, trip3;
   logic [2:0] en3, dira3, dirb3;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int ferr_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (frame_err) ferr_cnt++;

   motor_spi_pwm #(.NUM_CH(2), .DUTY_W(8), .PRESCALE(1), .WDOG_CYCLES(1000)) u_dut (
      .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load), .sdo(sdo),
      .en(en), .dir_a(dir_a), .dir_b(dir_b), .frame_err(frame_err), .wdog_trip(wdog_trip)
   );

   motor_spi_pwm #(.NUM_CH(3), .DUTY_W(12)) u_dut3 (
      .clk(clk), .reset(reset), .sck(sck3), .sdi(sdi3), .load(load3), .sdo(sdo3),
      .en(en3), .dir_a(dira3), .dir_b(dirb3), .frame_err(ferr3), .wdog_trip(trip3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_bits(input int sel, input logic [63:0] data, input int nbits);
      if (sel == 0) load = 1'b1; else load3 = 1'b1;
      cycles(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         if (sel == 0) sdi = data[i]; else sdi3 = data[i];
         cycles(4);
         if (sel == 0) sck = 1'b1; else sck3 = 1'b1;
         cycles(4);
         if (sel == 0) sck = 1'b0; else sck3 = 1'b0;
      end
      cycles(4);
   endtask

   task automatic send(input int sel, input logic [63:0] data, input int nbits);
      start_bits(sel, data, nbits);
      if (sel == 0) load = 1'b0; else load3 = 1'b0;
      cycles(8);
   endtask

   task automatic measure(input int sel, input int n, output int c0, output int c1,
                          output int c2);
      c0 = 0; c1 = 0; c2 = 0;
      repeat (n) begin
         @(negedge clk);
         if (sel == 0) begin
            c0 += int'(en[0]); c1 += int'(en[1]);
         end else begin
            c0 += int'(en3[0]); c1 += int'(en3[1]); c2 += int'(en3[2]);
         end
      end
   endtask

   initial begin
      int c0, c1, c2, f0, r0, rc;
      logic found, prev;
      reset = 1'b1;
      sck = 0; sdi = 0; load = 0;
      sck3 = 0; sdi3 = 0; load3 = 0;
      cycles(4);
      check("rst_en", en, 0);
      check("rst_dir_a", dir_a, 0);
      check("rst_dir_b", dir_b, 0);
      check("rst_sdo", sdo, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_wdog_trip", wdog_trip, 0);
      check("rst_en3", en3, 0);
      reset = 1'b0;
      cycles(4);

      // 0x55 -> +85, 0xAA -> -86
      f0 = ferr_cnt;
      send(0, 64'h55AA, 16);
      check("s1_no_ferr", ferr_cnt - f0, 0);
      cycles(130);
      measure(0, 127, c0, c1, c2);
      check("s1_duty0", c0, 85);
      check("s1_duty1", c1, 86);
      check("s1_dir_a", dir_a, 2'b01);
      check("s1_dir_b", dir_b, 2'b10);

      // Record the phase of the PWM wrap from a rising en0 edge
      found = 1'b0; r0 = 0; prev = en[0];
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (en[0] && !prev) begin found = 1'b1; r0 = cyc; end
         prev = en[0];
      end
      check("s1_en0_rise_seen", found, 1);

      // Short frame: error pulse, duties kept
      f0 = ferr_cnt;
      send(0, 64'h0, 15);
      check("s2_ferr_15", ferr_cnt - f0, 1);
      measure(0, 127, c0, c1, c2);
      check("s2_duty0", c0, 85);
      check("s2_duty1", c1, 86);

      // Long frame: error pulse, no commit
      send(0, 64'h55AA, 16);
      f0 = ferr_cnt;
      send(0, 64'h1FFFF, 17);
      check("s3_ferr_17", ferr_cnt - f0, 1);
      check("s3_sdo", sdo, 1);
      measure(0, 127, c0, c1, c2);
      check("s3_duty0", c0, 85);
      check("s3_duty1", c1, 86);

      // 0x80 saturates to full magnitude, reverse; 0x00 coasts
      send(0, 64'h8000, 16);
      found = 1'b0; rc = 0;
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         if (dir_b[0]) begin found = 1'b1; rc = cyc; end
      end
      check("s4_dir_change_seen", found, 1);
      check("s4_change_at_wrap", (rc - r0) % 127, 0);
      cycles(130);
      measure(0, 127, c0, c1, c2);
      check("s4_duty0", c0, 127);
      check("s4_duty1", c1, 0);
      check("s4_dir_a", dir_a, 2'b00);
      check("s4_dir_b", dir_b, 2'b01);

      // Reset mid-frame, then a clean frame
      start_bits(0, 64'h1FF, 9);
      reset = 1'b1; load = 1'b0; sck = 1'b0;
      cycles(4);
      check("s5_rst_en", en, 0);
      check("s5_rst_sdo", sdo, 0);
      reset = 1'b0;
      cycles(4);
      f0 = ferr_cnt;
      send(0, 64'h7F01, 16);
      check("s5_no_ferr", ferr_cnt - f0, 0);
      cycles(130);
      measure(0, 127, c0, c1, c2);
      check("s5_duty0", c0, 127);
      check("s5_duty1", c1, 1);
      check("s5_dir_a", dir_a, 2'b11);
      check("s5_dir_b", dir_b, 2'b00);

      send(0, 64'h4040, 16);
      cycles(130);
      measure(0, 127, c0, c1, c2);
      check("s6_duty0", c0, 64);
`ifdef WATCHDOG_EN
      cycles(580);
      check("s6_trip_early", wdog_trip, 0);
      cycles(200);
      check("s6_trip", wdog_trip, 1);
      check("s6_en_off", en, 0);
      check("s6_dir_a_off", dir_a, 0);
      check("s6_dir_b_off", dir_b, 0);
      send(0, 64'h4040, 16);
      check("s6_trip_clear", wdog_trip, 0);
      cycles(130);
      measure(0, 127, c0, c1, c2);
      check("s6_duty0_again", c0, 64);
`else
      cycles(1200);
      check("s6_no_trip", wdog_trip, 0);
      measure(0, 127, c0, c1, c2);
      check("s6_duty0_hold", c0, 64);
`endif

      // Wider configuration: +2047, -2048 (saturates), 0
      send(1, 64'h7FF800000, 36);
      check("s7_no_ferr", ferr3, 0);
      cycles(2050);
      measure(1, 2047, c0, c1, c2);
      check("s7_duty0", c0, 2047);
      check("s7_duty1", c1, 2047);
      check("s7_duty2", c2, 0);
      check("s7_dir_a", dira3, 3'b001);
      check("s7_dir_b", dirb3, 3'b010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/motor_spi_pwm.md
MOTOR_SPI_PWM -- requirements
Module: motor_spi_pwm

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of motor channels (1..8).
REQ-002 The block SHALL have parameter DUTY_W, default 8, meaning the per-channel signed two's-complement command width (4..16).
REQ-003 The block SHALL have parameter PRESCALE, default 1, meaning clk cycles per PWM counter tick (>=1).
REQ-004 The block SHALL have parameter WDOG_CYCLES, default 1000000, meaning the watchdog timeout in clk cycles.
REQ-005 The block SHALL have the following ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock, asynchronous, idle low; sdi sampled on its rising edge.
- sdi  input  1  SPI serial data in, MSB first.
- load  input  1  frame strobe; high while a frame shifts in, falling edge commits.
- sdo  output  1  SPI data out = MSB of the shift register.
- en  output  NUM_CH  per-channel PWM enable to H-bridge.
- dir_a  output  NUM_CH  per-channel direction leg A.
- dir_b  output  NUM_CH  per-channel direction leg B.
- frame_err  output  1  one-cycle pulse on a bad-length frame.
- wdog_trip  output  1  watchdog-expired status.

Function
REQ-006 sck, sdi and load SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on synchronized values; sck high and low phases are each >=3 clk cycles.
REQ-007 On each detected sck rising edge while synchronized load=1, the block SHALL shift sdi into a NUM_CH*DUTY_W-bit shift register at the LSB and increment a bit counter that saturates at NUM_CH*DUTY_W+1.
REQ-008 Frame order SHALL be channel 0 first (most significant DUTY_W bits), channel NUM_CH-1 last.
REQ-009 On a detected load rising edge, the bit counter SHALL clear to 0; the shift register SHALL be retained.
REQ-010 On a detected load falling edge with bit count == NUM_CH*DUTY_W, the shadow command registers SHALL load from the shift register on the next clk edge (commit).
REQ-011 On a detected load falling edge with any other bit count, frame_err SHALL pulse high for exactly one cycle and the shadow registers SHALL be unchanged.
REQ-012 Magnitude SHALL be |cmd| truncated to DUTY_W-1 bits; cmd = -2^(DUTY_W-1) SHALL saturate to 2^(DUTY_W-1)-1.
REQ-013 The PWM counter SHALL count 0..P-1 with P = 2^(DUTY_W-1)-1, advancing once every PRESCALE clk cycles, and shared by all channels.
REQ-014 The active command per channel SHALL load from its shadow only when the PWM counter wraps to 0, so no partial PWM period occurs.
REQ-015 en[i] SHALL be registered and equal (counter < active magnitude[i]); magnitude P SHALL give 100% duty and 0 SHALL give 0%.
REQ-016 For each channel i, dir_a/dir_b SHALL be registered from the active command:
- positive: dir_a=1, dir_b=0.
- negative: dir_a=0, dir_b=1.
- zero: both 0 (coast).
- dir_a and dir_b SHALL never be 1 simultaneously.
REQ-017 A load falling edge coinciding with an sck rising edge SHALL shift the bit first and then evaluate the count.

Reset
REQ-018 While reset=1 at a clk edge, the block SHALL clear the shift register, bit counter, shadow/active commands, PWM and prescale counters, and watchdog counter to 0, and set synchronizers to idle (0).
REQ-019 During reset, en, dir_a, dir_b, sdo, frame_err and wdog_trip SHALL all be 0.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame; the next frame SHALL start from bit 0.

Configuration
REQ-021 With WATCHDOG_EN defined:
- A counter SHALL clear on every commit and increment otherwise.
- On reaching WDOG_CYCLES, the block SHALL zero the shadow and active commands immediately (en=0 and dir=0 from the next cycle) and set wdog_trip=1.
- wdog_trip SHALL stay 1 until the next commit or reset.
REQ-022 Without WATCHDOG_EN, wdog_trip SHALL be tied 0, WDOG_CYCLES SHALL be unused, and commands SHALL hold indefinitely.

Verification
REQ-023 The bench SHALL cover the following scenarios (defaults unless stated):
- Frame {0x55,0xAA} -> ch0: en high 85 of 127 ticks, dir_a0=1/dir_b0=0; ch1: en high 86 of 127, dir_a1=0/dir_b1=1; change only at counter wrap.
- 15-bit frame -> one-cycle frame_err pulse; prior duties unchanged. 17-bit frame -> frame_err pulse; no commit.
- Frame {0x80,0x00} -> en0 constantly 1, dir_b0=1; en1=0, dir_a1=dir_b1=0.
- reset=1 after 9 bits, then full frame {0x7F,0x01} -> ch0 100%, ch1 1/127; no frame_err.
- WATCHDOG_EN, WDOG_CYCLES=1000: commit {0x40,0x40}, idle 1000 cycles -> en=0, wdog_trip=1; next valid frame clears wdog_trip.
- NUM_CH=3, DUTY_W=12: 36-bit frame {0x7FF,0x800,0x000} -> ch0/ch1 100% with opposite directions, ch2 coast.
